// File: rtl/aer_pkg.sv
// Shared types and constants for the AER event readout path.
// Imported by the FIFO reader and its word serializer.
package aer_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_SEND,
        RD_WAIT
    } rd_state_t;

    localparam int RD_SETTLE_DEF = 2;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/event_word_serializer.sv
// Splits one FIFO word into OUT_W-wide beats, least-significant first.
// Loads in parallel, shifts on each accepted beat.
module event_word_serializer
    import aer_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] data,
    input  logic              advance,
    output logic [OUT_W-1:0]  beat,
    output logic              last_beat
);

    localparam int NBEATS = DWIDTH / OUT_W;
    localparam int BW     = max_i($clog2(NBEATS), 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(NBEATS - 1);

    logic [DWIDTH-1:0] shreg;
    logic [BW-1:0]     beat_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            beat_idx <= '0;
        end else if (load) begin
            shreg    <= data;
            beat_idx <= '0;
        end else if (advance) begin
            shreg    <= shreg >> OUT_W;
            beat_idx <= beat_idx + BW'(1);
        end
    end

    assign beat      = shreg[OUT_W-1:0];
    assign last_beat = (beat_idx == LAST_IDX);

endmodule

// File: rtl/event_fifo_reader.sv
// Drains the event SRAM FIFO in bursts and serializes each word
// onto a narrow valid/ready stream.
module event_fifo_reader
    import aer_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int DEPTH     = 4096,
    parameter int OUT_W     = 16,
    parameter int SETTLE    = RD_SETTLE_DEF,
    parameter int MAX_BURST = 256,
    localparam int AWIDTH   = $clog2(DEPTH),
    localparam int LW       = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic [LW-1:0]     burst_len,
    input  logic              fifo_empty,
    input  logic [AWIDTH:0]   fifo_numel,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic [31:0]       words_sent
);

    localparam int CW = max_i(AWIDTH + 1, LW);
    localparam int SW = max_i($clog2(SETTLE + 1), 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [LW-1:0] MAX_LEN     = LW'(MAX_BURST);

    rd_state_t     state_q;
    rd_state_t     state_d;
    logic [LW-1:0] eff_len;
    logic [LW-1:0] first_len;
    logic [LW-1:0] words_left;
    logic [SW-1:0] settle_cnt;
    logic          flush_pend;
    logic          have_len;
    logic          start;
    logic          load;
    logic          fire;
    logic          last_beat;
    logic          word_done;

    always_comb begin
        eff_len = burst_len;
        if (burst_len == '0) begin
            eff_len = LW'(1);
        end else if (burst_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    // A short flush burst takes whatever is stored.
    assign have_len  = CW'(fifo_numel) >= CW'(eff_len);
    assign first_len = have_len ? eff_len : LW'(fifo_numel);
    assign start     = (en && have_len) || (flush_pend && !fifo_empty);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (start) state_d = RD_LOAD;
            RD_LOAD: state_d = RD_SEND;
            RD_SEND: if (word_done) state_d = RD_WAIT;
            RD_WAIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = (words_left != '0) ? RD_LOAD : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign load       = (state_q == RD_LOAD);
    assign fifo_rd_en = load;
    assign out_valid  = (state_q == RD_SEND);
    assign busy       = (state_q != RD_IDLE);
    assign fire       = out_valid && out_ready;
    assign word_done  = fire && last_beat;
    assign out_last   = out_valid && last_beat
                        && (words_left == LW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            words_left <= '0;
            words_sent <= '0;
            flush_pend <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state_q <= state_d;
            // A flush landing on a burst start survives for the next burst.
            if (flush) begin
                flush_pend <= 1'b1;
            end else if (state_q == RD_IDLE && (start || fifo_empty)) begin
                flush_pend <= 1'b0;
            end
            if (state_q == RD_IDLE && start) begin
                words_left <= first_len;
            end else if (word_done) begin
                words_left <= words_left - LW'(1);
            end
            if (word_done) begin
                words_sent <= words_sent + 32'd1;
            end
            if (state_q == RD_WAIT) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    event_word_serializer #(
        .DWIDTH (DWIDTH),
        .OUT_W  (OUT_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      (fifo_rdata),
        .advance   (fire),
        .beat      (out_data),
        .last_beat (last_beat)
    );

endmodule

// File: doc/event_fifo_reader.md
# event_fifo_reader

Drain side of the event SRAM FIFO: pops 64-bit event words from `sram_fifo_wrapper` through its `fifo_rd_en` / `fifo_rdata` / `fifo_empty` / `fifo_numel` port and serializes them onto a narrower valid/ready output stream in bursts. It sits between the FIFO wrapper and the readout/host link, and is the only reader of the FIFO. A burst starts once enough words are stored, or on a flush request. `out_last` marks the final beat of each burst.

## Interface
- `DWIDTH`, 64, FIFO word width; must be a multiple of `OUT_W`.
- `DEPTH`, 4096, FIFO depth; `AWIDTH = $clog2(DEPTH)`.
- `OUT_W`, 16, output beat width; `NBEATS = DWIDTH/OUT_W`.
- `SETTLE`, 2, cycles to wait after a pop before the FIFO's `fifo_rdata` is valid again; minimum 1.
- `MAX_BURST`, 256, largest burst length in words.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  allows new bursts to start.
- `flush`  in  1  single-cycle pulse requesting that the FIFO contents be drained.
- `burst_len`  in  `$clog2(MAX_BURST)+1`  words per burst; 0 is treated as 1; values above `MAX_BURST` are clipped to `MAX_BURST`.
- `fifo_empty`  in  1  from the wrapper.
- `fifo_numel`  in  `AWIDTH+1`  from the wrapper.
- `fifo_rdata`  in  `DWIDTH`  show-ahead head word; valid when `!fifo_empty`.
- `fifo_rd_en`  out  1  pop strobe.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  `OUT_W`  beat payload.
- `out_last`  out  1  final beat of the burst.
- `busy`  out  1  high in every state except IDLE.
- `words_sent`  out  32  count of completed words; wraps at 2^32.

## Operation
- States:
  - IDLE → LOAD when `start` is true. `start = en && fifo_numel >= eff_len`, or `flush_pend && !fifo_empty`.
  - On entering LOAD, latch `words_left = min(fifo_numel, eff_len)`, where `eff_len` is the clipped `burst_len`. Clear `flush_pend`.
  - LOAD: capture `fifo_rdata` into a shift register, set `beat_idx = 0`, and assert `fifo_rd_en` for exactly this cycle. → SEND.
  - SEND: drive `out_valid=1` with `out_data` taken from shift-register bits `[OUT_W-1:0]`, least-significant beat first. On `out_valid && out_ready`, shift right by `OUT_W` and increment `beat_idx`. On the acceptance of beat `NBEATS-1`, increment `words_sent`, decrement `words_left`, and go → WAIT.
  - WAIT: count `SETTLE` cycles. Then go → LOAD if `words_left != 0`, else → IDLE.
- `out_last = out_valid && beat_idx == NBEATS-1 && words_left == 1`.
- Because this block is the only reader, `fifo_numel` cannot drop during a burst. The latched `words_left` therefore never starves. `fifo_empty` is not re-checked mid-burst.
- `flush` sets `flush_pend` in any state. If `flush_pend` is set while IDLE and `fifo_empty` is high, clear it with no output.
- Deasserting `en` mid-burst does not abort the burst; the burst completes.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake.

## Timing
- Reset values: state IDLE; `fifo_rd_en`, `out_valid`, `out_last`, `busy` = 0; `out_data` = 0; `words_sent` = 0; `flush_pend` = 0; `words_left` = 0.
- Reset applied mid-burst: return to IDLE on the next edge; the partly sent word is lost. FIFO contents are untouched, since this block never drives `fifo_rst_n`.
- `start` sampled at edge N → LOAD in cycle N+1 (`fifo_rd_en` high) → first beat valid in cycle N+2.
- With `out_ready` held high, one word occupies 1 (LOAD) + `NBEATS` (SEND) + `SETTLE` (WAIT) cycles. With the defaults that is 7 cycles per word.
- A `flush` pulse arriving on the same edge as a burst start is latched and serviced after the current burst.

## Structure
- `aer_pkg` holds the typedef `rd_state_t {RD_IDLE, RD_LOAD, RD_SEND, RD_WAIT}` and the constant `RD_SETTLE_DEF = 2`.
- Sub-module `event_word_serializer` (parallel load, shift on handshake, beat counter) is the natural split. The FSM and burst accounting stay in `event_fifo_reader`.

## Test plan
- Single-word flush: write `0x1111_2222_3333_4444`, pulse `flush`, hold `out_ready=1` → beats `0x4444`, `0x3333`, `0x2222`, `0x1111`; `out_last` on the 4th beat only; exactly one `fifo_rd_en` pulse; `words_sent=1`.
- Threshold: `burst_len=8`, `en=1`, write words 1..7 → no `fifo_rd_en`. Write an 8th word → 32 beats, `out_last` on beat 32, `words_sent=8`, `fifo_numel=0`.
- Backpressure: toggle `out_ready` randomly during a 4-word burst → `out_data` stable while stalled; beat sequence matches the stored words in order.
- Flush on empty: pulse `flush` with the FIFO empty → no `out_valid`, `busy` stays 0. A later write with `en=0` produces no output.
- Reset mid-burst: assert `rst` after beat 2 of word 1 → next cycle `out_valid=0`, `busy=0`, `words_sent=0`; unread words remain in the FIFO.
- Full FIFO: fill 4096 words, `burst_len=256`, `en=1` → 16 bursts, 16384 beats, data equals `j+1` in order, `words_sent=4096`, `fifo_empty=1`.
